muldiv: RTL and testbench

Iterative 64-bit RV64M multiply/divide unit: the responder behind the execute stage's multiply/divide request interface. It accepts the execute stage's forwarded operands, per-operand sign flags and request valid. It runs a 64-iteration shift-add multiply or restoring divide, then returns low/high result words that the execute stage's write-back mux selects. It also drives the stall that holds the pipeline while a request is in flight.

---
 rtl/muldiv_pkg.sv | 43 ++++
 rtl/muldiv_neg.sv | 21 ++
 rtl/muldiv.sv | 181 ++++++++++++++++++
 tb/tb_muldiv.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative RV64M multiply/divide unit.
//   - FSM state encoding (IDLE/BUSY/DONE)
//   - RV64M funct3 encodings for the M-extension instructions
//   - operand sign-flag encodings
//   - iteration count and counter width
//   - helpers for 32-bit (*W) operand extension and result sign extension
package muldiv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } muldiv_state_e;

   localparam logic [2:0] funct3_mul    = 3'b000;
   localparam logic [2:0] funct3_mulh   = 3'b001;
   localparam logic [2:0] funct3_mulhsu = 3'b010;
   localparam logic [2:0] funct3_mulhu  = 3'b011;
   localparam logic [2:0] funct3_div    = 3'b100;
   localparam logic [2:0] funct3_divu   = 3'b101;
   localparam logic [2:0] funct3_rem    = 3'b110;
   localparam logic [2:0] funct3_remu   = 3'b111;

   localparam logic MULDIV_SIGN   = 1'b1;
   localparam logic MULDIV_UNSIGN = 1'b0;

   localparam int MULDIV_ITER  = 64;
   localparam int MULDIV_CNT_W = 6;

   // Sign-extend the low word of a 64-bit value.
   function automatic logic [63:0] sext32(input logic [63:0] v);
      return {{32{v[31]}}, v[31:0]};
   endfunction

   // Extend the low word of an operand according to its sign flag.
   function automatic logic [63:0] word_ext(input logic [63:0] v, input logic sign);
      if (sign == MULDIV_UNSIGN) begin
         return {32'h0, v[31:0]};
      end
      return {{32{v[31]}}, v[31:0]};
   endfunction

endpackage

// File: rtl/muldiv_neg.sv
// muldiv_neg: conditional two's-complement negation.
// Ports:
//   en  - 1 = output the two's complement of a, 0 = pass a through
//   a   - input value (WIDTH bits)
//   y   - result (WIDTH bits)
module muldiv_neg #(
   parameter int WIDTH = 64
) (
   input  logic             en,
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      y = a;
      if (en) begin
         y = ~a + WIDTH'(1);
      end
   end

endmodule

// File: rtl/muldiv.sv
// muldiv: iterative 64-bit RV64M multiply/divide unit behind the execute stage.
// Multiply is a 64-step unsigned shift-add on operand magnitudes (LSB first);
// divide is a 64-step restoring division (MSB first). Signs are applied to the
// finished magnitude result. Divide-by-zero and signed overflow complete
// directly from IDLE without iterating.
// Ports:
//   clk, rst                  - clock, asynchronous active-low reset
//   muldiv_req_valid_i        - request held while the instruction is in execute
//   muldiv_rs1/rs2_data_i     - forwarded operands
//   muldiv_rs1/rs2_sign_i     - 1 = operand is signed
//   funct3_i                  - M-extension funct3 (bit 2 selects divide)
//   word_i                    - *W variant
//   flush_i                   - pipeline flush, aborts any operation
//   muldiv_result_l_o/_h_o    - product low/high or quotient/remainder
//   muldiv_result_valid_o     - one-cycle completion pulse
//   muldiv_stall_o            - holds the pipeline while a request is in flight
module muldiv
   import muldiv_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            muldiv_req_valid_i,
   input  logic [XLEN-1:0] muldiv_rs1_data_i,
   input  logic [XLEN-1:0] muldiv_rs2_data_i,
   input  logic            muldiv_rs1_sign_i,
   input  logic            muldiv_rs2_sign_i,
   input  logic [2:0]      funct3_i,
   input  logic            word_i,
   input  logic            flush_i,
   output logic [XLEN-1:0] muldiv_result_l_o,
   output logic [XLEN-1:0] muldiv_result_h_o,
   output logic            muldiv_result_valid_o,
   output logic            muldiv_stall_o
);

   localparam logic [MULDIV_CNT_W-1:0] CNT_LAST = MULDIV_CNT_W'(MULDIV_ITER - 1);

   muldiv_state_e state, state_nx;
   logic [MULDIV_CNT_W-1:0] count;

   // Operand preparation (combinational, used while IDLE)
   logic [XLEN-1:0] rs1_ext, rs2_ext, rs1_mag, rs2_mag, most_neg;
   logic            rs1_neg, rs2_neg, req_is_div;
   logic            div_by_zero, div_ovf, special;
   logic [XLEN-1:0] spec_q, spec_r;

   // Latched operation context
   logic [XLEN-1:0] acc_hi, acc_lo, opb;
   logic            neg_res, neg_rem, op_div, op_word;

   // One iteration step and result fix-up
   logic [XLEN:0]     mul_sum, div_shift, div_diff;
   logic [XLEN-1:0]   acc_hi_nx, acc_lo_nx;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quot_fix, rem_fix, fin_l, fin_h;

   logic accept, finish;

   always_comb begin
      rs1_ext    = word_i ? word_ext(muldiv_rs1_data_i, muldiv_rs1_sign_i) : muldiv_rs1_data_i;
      rs2_ext    = word_i ? word_ext(muldiv_rs2_data_i, muldiv_rs2_sign_i) : muldiv_rs2_data_i;
      rs1_neg    = (muldiv_rs1_sign_i == MULDIV_SIGN) & rs1_ext[XLEN-1];
      rs2_neg    = (muldiv_rs2_sign_i == MULDIV_SIGN) & rs2_ext[XLEN-1];
      req_is_div = funct3_i inside {funct3_div, funct3_divu, funct3_rem, funct3_remu};
      // Most-negative dividend as seen after *W sign extension.
      most_neg   = word_i ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
      div_by_zero = req_is_div & (rs2_ext == '0);
      div_ovf     = req_is_div & muldiv_rs1_sign_i & muldiv_rs2_sign_i
                    & (rs1_ext == most_neg) & (&rs2_ext);
      special     = div_by_zero | div_ovf;
      spec_q      = div_by_zero ? '1 : rs1_ext;
      spec_r      = div_by_zero ? rs1_ext : '0;
      if (word_i) begin
         spec_q = sext32(spec_q);
         spec_r = sext32(spec_r);
      end
   end

   muldiv_neg #(.WIDTH(XLEN)) u_rs1_mag (.en(rs1_neg), .a(rs1_ext), .y(rs1_mag));
   muldiv_neg #(.WIDTH(XLEN)) u_rs2_mag (.en(rs2_neg), .a(rs2_ext), .y(rs2_mag));

   // Shared accumulator pair: for multiply {acc_hi,acc_lo} is the partial
   // product with the multiplier shifting out of acc_lo; for divide acc_hi is
   // the partial remainder and acc_lo shifts dividend bits out / quotient in.
   always_comb begin
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
      div_shift = {acc_hi, acc_lo[XLEN-1]};
      // The partial remainder is always below the divisor, so a non-borrowing
      // difference fits in XLEN bits.
      div_diff  = div_shift - {1'b0, opb};
      if (op_div) begin
         if (!div_diff[XLEN]) begin
            acc_hi_nx = div_diff[XLEN-1:0];
            acc_lo_nx = {acc_lo[XLEN-2:0], 1'b1};
         end else begin
            acc_hi_nx = div_shift[XLEN-1:0];
            acc_lo_nx = {acc_lo[XLEN-2:0], 1'b0};
         end
      end else begin
         acc_hi_nx = mul_sum[XLEN:1];
         acc_lo_nx = {mul_sum[0], acc_lo[XLEN-1:1]};
      end
   end

   // Sign fix-up is applied to the final step's output so the result is
   // ready on the edge that enters DONE.
   muldiv_neg #(.WIDTH(2*XLEN)) u_prod_fix (.en(neg_res), .a({acc_hi_nx, acc_lo_nx}), .y(prod_fix));
   muldiv_neg #(.WIDTH(XLEN))   u_quot_fix (.en(neg_res), .a(acc_lo_nx), .y(quot_fix));
   muldiv_neg #(.WIDTH(XLEN))   u_rem_fix  (.en(neg_rem), .a(acc_hi_nx), .y(rem_fix));

   always_comb begin
      if (op_div) begin
         fin_l = op_word ? sext32(quot_fix) : quot_fix;
         fin_h = op_word ? sext32(rem_fix)  : rem_fix;
      end else begin
         fin_l = op_word ? sext32(prod_fix[XLEN-1:0]) : prod_fix[XLEN-1:0];
         fin_h = op_word ? '0 : prod_fix[2*XLEN-1:XLEN];
      end
   end

   // Next-state and handshake outputs
   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE: if (muldiv_req_valid_i) state_nx = special ? ST_DONE : ST_BUSY;
         ST_BUSY: if (count == CNT_LAST) state_nx = ST_DONE;
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
      if (flush_i) begin
         state_nx = ST_IDLE;
      end
      accept                = (state == ST_IDLE) & muldiv_req_valid_i & ~flush_i;
      finish                = (state == ST_BUSY) & (count == CNT_LAST) & ~flush_i;
      muldiv_result_valid_o = (state == ST_DONE) & ~flush_i;
      muldiv_stall_o        = muldiv_req_valid_i & ~muldiv_result_valid_o;
   end

   // Control and architectural result registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state             <= ST_IDLE;
         count             <= '0;
         muldiv_result_l_o <= '0;
         muldiv_result_h_o <= '0;
      end else begin
         state <= state_nx;
         if (flush_i || state != ST_BUSY) begin
            count <= '0;
         end else begin
            count <= count + MULDIV_CNT_W'(1);
         end
         if (accept && special) begin
            muldiv_result_l_o <= spec_q;
            muldiv_result_h_o <= spec_r;
         end else if (finish) begin
            muldiv_result_l_o <= fin_l;
            muldiv_result_h_o <= fin_h;
         end
      end
   end

   // Datapath registers; only meaningful while BUSY, so no reset needed
   always_ff @(posedge clk) begin
      if (accept) begin
         acc_hi  <= '0;
         acc_lo  <= rs1_mag;
         opb     <= rs2_mag;
         neg_res <= rs1_neg ^ rs2_neg;
         neg_rem <= rs1_neg;
         op_div  <= req_is_div;
         op_word <= word_i;
      end else if (state == ST_BUSY) begin
         acc_hi <= acc_hi_nx;
         acc_lo <= acc_lo_nx;
      end
   end

endmodule

// File: tb/tb_muldiv.sv
module tb_muldiv;

   logic        clk = 1'b0;
   logic        rst;
   logic        req, s1, s2, word, flush;
   logic [63:0] rs1, rs2;
   logic [2:0]  f3;
   logic [63:0] res_l, res_h;
   logic        valid, stall;

   int checks   = 0;
   int failures = 0;
   logic [63:0] last_l = '0, last_h = '0;

   muldiv #(.XLEN(64)) dut (
      .clk                   (clk),
      .rst                   (rst),
      .muldiv_req_valid_i    (req),
      .muldiv_rs1_data_i     (rs1),
      .muldiv_rs2_data_i     (rs2),
      .muldiv_rs1_sign_i     (s1),
      .muldiv_rs2_sign_i     (s2),
      .funct3_i              (f3),
      .word_i                (word),
      .flush_i               (flush),
      .muldiv_result_l_o     (res_l),
      .muldiv_result_h_o     (res_h),
      .muldiv_result_valid_o (valid),
      .muldiv_stall_o        (stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] sx32(input logic [63:0] v);
      return {{32{v[31]}}, v[31:0]};
   endfunction

   // Reference: mathematical product / truncating quotient of the extended
   // operands interpreted per their sign flags, at 128-bit precision.
   function automatic void ref_model(input logic [63:0] a, input logic [63:0] b,
                                     input logic sa, input logic sb, input logic [2:0] op,
                                     input logic w, output logic [63:0] l,
                                     output logic [63:0] h, output int lat);
      logic [63:0] ae, be, mn;
      logic signed [127:0] xa, xb, p, q, r;
      ae = w ? (sa ? {{32{a[31]}}, a[31:0]} : {32'h0, a[31:0]}) : a;
      be = w ? (sb ? {{32{b[31]}}, b[31:0]} : {32'h0, b[31:0]}) : b;
      xa = sa ? {{64{ae[63]}}, ae} : {64'h0, ae};
      xb = sb ? {{64{be[63]}}, be} : {64'h0, be};
      lat = 65;
      if (!op[2]) begin
         p = xa * xb;
         l = w ? sx32(p[63:0]) : p[63:0];
         h = w ? 64'h0 : p[127:64];
      end else if (be == 64'h0) begin
         lat = 1;
         l = '1;
         h = w ? sx32(ae) : ae;
      end else begin
         mn = w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
         if (sa && sb && ae == mn && be == '1) lat = 1;
         q = xa / xb;
         r = xa % xb;
         l = w ? sx32(q[63:0]) : q[63:0];
         h = w ? sx32(r[63:0]) : r[63:0];
      end
   endfunction

   // Issue one request at the next negedge (cycle 0) and follow it to DONE.
   // Leaves the request asserted; the caller decides what follows.
   task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic sa, input logic sb, input logic [2:0] op, input logic w,
                         input logic [63:0] el, input logic [63:0] eh, input int lat);
      int n;
      logic stall_ok;
      @(negedge clk);
      req = 1'b1; rs1 = a; rs2 = b; s1 = sa; s2 = sb; f3 = op; word = w;
      #1;
      stall_ok = (stall === 1'b1) && (valid === 1'b0);
      n = 0;
      while (n < 200) begin
         @(negedge clk);
         n++;
         if (valid === 1'b1) break;
         if (stall !== 1'b1) stall_ok = 1'b0;
      end
      chk({tag, "_latency"}, 64'(n), 64'(lat));
      chk({tag, "_stall_held"}, 64'(stall_ok), 64'h1);
      chk({tag, "_stall_drop"}, 64'(stall), 64'h0);
      chk({tag, "_l"}, res_l, el);
      chk({tag, "_h"}, res_h, eh);
      last_l = el;
      last_h = eh;
   endtask

   task automatic end_op(input string tag);
      req = 1'b0;
      @(negedge clk);
      #1;
      chk({tag, "_valid_one_cycle"}, 64'(valid), 64'h0);
      chk({tag, "_l_held"}, res_l, last_l);
   endtask

   task automatic watch_no_valid(input string tag, input int cycles);
      int seen;
      seen = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (valid === 1'b1) seen++;
      end
      chk({tag, "_no_valid"}, 64'(seen), 64'h0);
   endtask

   function automatic logic [63:0] pick_operand();
      logic [63:0] v;
      case ($urandom_range(0, 7))
         0: v = 64'h0;
         1: v = '1;
         2: v = 64'h8000_0000_0000_0000;
         3: v = 64'h0000_0000_8000_0000;
         4: v = {56'h0, 8'($urandom())};
         default: v = {$urandom(), $urandom()};
      endcase
      return v;
   endfunction

   initial begin
      logic [63:0] el, eh, a, b;
      logic [2:0]  op;
      logic        sa, sb, w;
      int          lat;

      rst = 1'b1; req = 1'b0; rs1 = '0; rs2 = '0; s1 = 1'b0; s2 = 1'b0;
      f3 = 3'b000; word = 1'b0; flush = 1'b0;
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_l", res_l, 64'h0);
      chk("reset_h", res_h, 64'h0);
      chk("reset_valid", 64'(valid), 64'h0);
      req = 1'b1;
      #1;
      chk("reset_stall_follows_req", 64'(stall), 64'h1);
      req = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      // Directed cases
      run_op("mul_neg3x7", -64'sd3, 64'd7, 1'b1, 1'b1, 3'b000, 1'b0,
             64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFF_FFFF_FFFF, 65);
      end_op("mul_neg3x7");
      run_op("mulhu_max", '1, '1, 1'b0, 1'b0, 3'b011, 1'b0,
             64'h1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
      end_op("mulhu_max");
      run_op("div_neg7by2", -64'sd7, 64'd2, 1'b1, 1'b1, 3'b100, 1'b0,
             64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65);
      end_op("div_neg7by2");
      run_op("divu_by0", 64'h1234, 64'h0, 1'b0, 1'b0, 3'b101, 1'b0,
             64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1);
      end_op("divu_by0");
      run_op("divw_ovf", 64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b1, 3'b100, 1'b1,
             64'hFFFF_FFFF_8000_0000, 64'h0, 1);
      end_op("divw_ovf");
      run_op("div64_ovf", 64'h8000_0000_0000_0000, '1, 1'b1, 1'b1, 3'b110, 1'b0,
             64'h8000_0000_0000_0000, 64'h0, 1);
      end_op("div64_ovf");

      // Back-to-back: the second request is accepted in the cycle after DONE
      run_op("b2b_first", 64'd100, 64'd7, 1'b0, 1'b0, 3'b101, 1'b0, 64'd14, 64'd2, 65);
      run_op("b2b_second", 64'd6, 64'd9, 1'b1, 1'b1, 3'b000, 1'b0, 64'd54, 64'd0, 65);
      end_op("b2b_second");

      // Flush in cycle 30 of a divide: abort, no pulse, results retained
      @(negedge clk);
      req = 1'b1; rs1 = 64'd1000; rs2 = 64'd3; s1 = 1'b1; s2 = 1'b1; f3 = 3'b100; word = 1'b0;
      repeat (30) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0; req = 1'b0;
      watch_no_valid("flush_busy", 80);
      chk("flush_l_kept", res_l, last_l);
      chk("flush_h_kept", res_h, last_h);

      // Flush together with a request in IDLE: the request is ignored
      @(negedge clk);
      req = 1'b1; rs1 = 64'h55; rs2 = 64'h0; s1 = 1'b0; s2 = 1'b0; f3 = 3'b101; flush = 1'b1;
      @(negedge clk);
      req = 1'b0; flush = 1'b0;
      watch_no_valid("flush_idle_req", 5);
      chk("flush_idle_l_kept", res_l, last_l);

      // Unit is idle again after the flush
      run_op("after_flush", 64'd1000, 64'd3, 1'b1, 1'b1, 3'b110, 1'b0, 64'd333, 64'd1, 65);
      end_op("after_flush");

      // Randomized operations against the reference model
      for (int i = 0; i < 16; i++) begin
         op = 3'($urandom_range(0, 7));
         case (op)
            3'b010:                 begin sa = 1'b1; sb = 1'b0; end
            3'b011, 3'b101, 3'b111: begin sa = 1'b0; sb = 1'b0; end
            default:                begin sa = 1'b1; sb = 1'b1; end
         endcase
         w = ($urandom_range(0, 3) == 0);
         a = pick_operand();
         b = pick_operand();
         ref_model(a, b, sa, sb, op, w, el, eh, lat);
         run_op($sformatf("rand%0d_f3_%0d_w%0d", i, op, w), a, b, sa, sb, op, w, el, eh, lat);
         end_op($sformatf("rand%0d", i));
      end

      // Reset in cycle 10 of a multiply: outputs clear immediately, no late result
      run_op("pre_reset", 64'd12345, 64'd678, 1'b0, 1'b0, 3'b000, 1'b0, 64'd8369910, 64'd0, 65);
      end_op("pre_reset");
      @(negedge clk);
      req = 1'b1; rs1 = 64'd99; rs2 = 64'd77; s1 = 1'b0; s2 = 1'b0; f3 = 3'b000; word = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midreset_l", res_l, 64'h0);
      chk("midreset_h", res_h, 64'h0);
      chk("midreset_valid", 64'(valid), 64'h0);
      chk("midreset_stall", 64'(stall), 64'h1);
      @(negedge clk);
      rst = 1'b1; req = 1'b0;
      watch_no_valid("after_reset", 80);
      chk("after_reset_l", res_l, 64'h0);
      last_l = '0;
      last_h = '0;
      run_op("post_reset_divw", 64'hFFFF_FFF9, 64'd2, 1'b1, 1'b1, 3'b110, 1'b1,
             64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65);
      end_op("post_reset_divw");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
